stream_window_combiner: RTL and testbench

- Parametrised elastic delay pipeline with a per-sample combine operator; successor to the fixed-latency shift-register test box.
- Carries a two-operand sample (in1, in2, mode) through LATENCY register stages with valid/ready back-pressure and a synchronous flush.
- Output combines the arriving sample with the previously emitted sample, or adds its two operands.
- Used as a verilog-box latency/stall test load behind stream producers.

---
 rtl/stream_combiner_pkg.sv | 34 +++
 rtl/pipe_stage.sv | 47 ++++
 rtl/stream_window_combiner.sv | 90 +++++++++
 tb/tb_stream_window_combiner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_combiner_pkg.sv
// Shared definitions for the stream window combiner: combine-mode encodings
// and the per-sample combine operator.
package stream_combiner_pkg;

  localparam logic [1:0] MODE_OR  = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;
  localparam logic [1:0] MODE_ADD = 2'd3;

  // Widest datapath the combine function handles; callers zero-extend their
  // operands and keep the low WIDTH bits of the result (addition carries
  // only move upward, so truncation gives the correct mod 2^WIDTH sum).
  localparam int MAX_WIDTH = 256;

  // Bitwise ops merge the sample with the last emitted value; ADD ignores
  // hist and sums the two operands of the sample itself.
  function automatic logic [MAX_WIDTH-1:0] combine(
    input logic [1:0]           mode,
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic [MAX_WIDTH-1:0] hist
  );
    logic [MAX_WIDTH-1:0] res;
    case (mode)
      MODE_OR:  res = a | hist;
      MODE_AND: res = a & hist;
      MODE_XOR: res = a ^ hist;
      MODE_ADD: res = a + b;
      default:  res = a | hist;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus payload, both advancing on
// enable. The synchronous flush only clears the valid bit; payload contents
// of an invalid slot are meaningless.
module pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);

  logic          valid_r;
  logic [PW-1:0] data_r;

  // Valid bit: flush wins over shifting, otherwise take upstream valid on advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (enable) begin
      valid_r <= in_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: shifts with the pipeline, holds during a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_r <= {PW{1'b0}};
    end else if (enable) begin
      data_r <= in_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/stream_window_combiner.sv
// Elastic LATENCY-deep delay pipeline carrying {mode, in2, in1}. The last
// stage is combined with the previously emitted operand (hist) or, in ADD
// mode, with its own second operand. Bubbles are carried, not collapsed:
// the whole chain either shifts or holds as one.
module stream_window_combiner
  import stream_combiner_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in1,
  input  logic [WIDTH-1:0]             in2,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic [$clog2(LATENCY+1)-1:0] occupancy
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int OW = $clog2(LATENCY + 1);

  // Index 0 is the input side, index LATENCY is the output of the last stage.
  logic [LATENCY:0]         chain_v_s;
  logic [LATENCY:0][PW-1:0] chain_d_s;
  logic                     advance_s;
  logic [WIDTH-1:0]         a_last_s;
  logic [WIDTH-1:0]         b_last_s;
  logic [1:0]               m_last_s;
  logic [WIDTH-1:0]         hist_r;
  logic [OW-1:0]            occ_s;

  assign advance_s    = !chain_v_s[LATENCY] || out_ready;
  assign chain_v_s[0] = in_valid;
  assign chain_d_s[0] = {mode, in2, in1};

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    pipe_stage #(.PW(PW)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .enable    (advance_s),
      .in_valid  (chain_v_s[k]),
      .in_data   (chain_d_s[k]),
      .out_valid (chain_v_s[k+1]),
      .out_data  (chain_d_s[k+1])
    );
  end

  assign a_last_s = chain_d_s[LATENCY][WIDTH-1:0];
  assign b_last_s = chain_d_s[LATENCY][2*WIDTH-1:WIDTH];
  assign m_last_s = chain_d_s[LATENCY][PW-1:PW-2];

  // Remember the operand of the last sample the consumer actually took.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      hist_r <= {WIDTH{1'b0}};
    end else if (chain_v_s[LATENCY] && out_ready) begin
      hist_r <= a_last_s;
    end else begin
      hist_r <= hist_r;
    end
  end

  // Count occupied stages; derived from the valid bits so it tracks every shift.
  always_comb begin
    occ_s = {OW{1'b0}};
    for (int k = 1; k <= LATENCY; k++) begin
      occ_s = occ_s + OW'(chain_v_s[k]);
    end
  end

  // Combine the head-of-pipe sample with hist (or its own second operand).
  always_comb begin
    out = WIDTH'(combine(m_last_s, MAX_WIDTH'(a_last_s), MAX_WIDTH'(b_last_s),
                         MAX_WIDTH'(hist_r)));
  end

  assign in_ready  = advance_s;
  assign out_valid = chain_v_s[LATENCY];
  assign occupancy = occ_s;

endmodule

// File: tb/tb_stream_window_combiner.sv
// Directed bench for stream_window_combiner at WIDTH=8, LATENCY=4.
module tb_stream_window_combiner;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [2:0] occupancy;

  int checks;
  int failures;

  stream_window_combiner #(.WIDTH(8), .LATENCY(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] m;
    logic       clr;
    logic       eov;
    logic [7:0] eout;
    logic [2:0] eocc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] m, input logic clr, input logic eov,
                     input logic [7:0] eout, input logic [2:0] eocc);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.m = m; v.clr = clr;
    v.eov = eov; v.eout = eout; v.eocc = eocc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] a, input logic [1:0] m,
                       input logic ordy, input logic clr);
    @(posedge clock);
    #1;
    in_valid  = iv;
    in1       = a;
    in2       = 8'h00;
    mode      = m;
    out_ready = ordy;
    clear     = clr;
  endtask

  int         acc;
  int         nout;
  logic [7:0] got[$];
  logic [7:0] exp3[6];
  logic [7:0] first_out;
  logic       seen;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in1 = 8'h00; in2 = 8'h00;
    mode = 2'd0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out", {24'd0, out}, 32'd0);
    reset = 1'b1;

    // OR stream, ADD wrap + hist load, clear, bubble (iv a b m clr | eov eout eocc)
    add(1'b1, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0);
    add(1'b1, 8'h02, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b1, 8'h04, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd2);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd3);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'h01, 3'd3);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'h03, 3'd2);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'h06, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0);
    add(1'b1, 8'hF0, 8'h20, 2'd3, 1'b0, 1'b0, 8'h00, 3'd0);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'h10, 3'd1);
    add(1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'hF0, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 8'h0F, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00, 3'd0);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b1, 8'hFF, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd2);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'h0F, 3'd2);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 8'hF0, 3'd1);
    add(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock);
      #1;
      in_valid = tbl[i].iv; in1 = tbl[i].a; in2 = tbl[i].b; mode = tbl[i].m;
      clear = tbl[i].clr; out_ready = 1'b1;
      @(negedge clock);
      chk($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
      chk($sformatf("row%0d_occupancy", i), {29'd0, occupancy}, {29'd0, tbl[i].eocc});
      chk($sformatf("row%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      if (tbl[i].eov) chk($sformatf("row%0d_out", i), {24'd0, out}, {24'd0, tbl[i].eout});
    end

    // Back-pressure: flush hist first, then six XOR samples with a 4-cycle stall
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
    exp3[0] = 8'h11; exp3[1] = 8'h03; exp3[2] = 8'h01;
    exp3[3] = 8'h07; exp3[4] = 8'h01; exp3[5] = 8'h03;
    acc = 0;
    for (int t = 0; t < 40 && got.size() < 6; t++) begin
      drive(acc < 6, 8'h11 + 8'(acc), 2'd2, !(t >= 3 && t <= 6), 1'b0);
      @(negedge clock);
      if (t == 4) begin
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_occupancy_full", {29'd0, occupancy}, 32'd4);
      end
      if (t >= 4 && t <= 6) begin
        chk($sformatf("bp_hold_valid_t%0d", t), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp_hold_out_t%0d", t), {24'd0, out}, 32'h11);
      end
      if (out_valid && out_ready) got.push_back(out);
      if (in_valid && in_ready) acc++;
    end
    chk("bp_accepted", acc, 32'd6);
    chk("bp_emitted", got.size(), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk($sformatf("bp_drain%0d", i), {24'd0, got[i]}, {24'd0, exp3[i]});

    // Clear mid-flight with an input offered in the clear cycle
    drive(1'b1, 8'h01, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 8'h40, 2'd0, 1'b1, 1'b1);
    drive(1'b1, 8'h80, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    chk("clr_occupancy", {29'd0, occupancy}, 32'd0);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    nout = 0; seen = 1'b0; first_out = 8'h00;
    for (int t = 0; t < 12; t++) begin
      drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
      @(negedge clock);
      if (out_valid) begin
        nout++;
        if (!seen) first_out = out;
        seen = 1'b1;
      end
    end
    chk("clr_emit_count", nout, 32'd1);
    chk("clr_first_out", {24'd0, first_out}, 32'h80);

    // Async reset mid-stream
    drive(1'b1, 8'h01, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    chk("ar_pre_occupancy", {29'd0, occupancy}, 32'd3);
    #2;
    reset = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_occupancy", {29'd0, occupancy}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 8'h05, 2'd0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      drive(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        chk("ar_first_out", {24'd0, out}, 32'h05);
      end
    end
    chk("ar_emitted", {31'd0, seen}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
